data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressable data memory for the 16-bit pipeline's MEM stage.
- Synchronous write, combinational read; supports 1-byte and 2-byte accesses, little-endian.
- The stage drives the ALU result as the address and selects the write data: register data or immediate.
- The read data is sampled by the stage's write-back register on the same clock edge that the address is presented.

Parameters:
- MEM_BYTES, 1024, number of byte locations; must be a power of two, ≤ 65536.
- ADDR_W, 16, width of the address port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wrEnable  input  1  write strobe, sampled at the rising clk edge.
- rdEnable  input  1  read enable; gates `out`.
- numberOfByte  input  2  access size: 2'd1 = one byte; any other value = two bytes.
- address  input  ADDR_W  byte address.
- in  input  16  write data.
- out  output  16  read data, combinational.

Behaviour:
- Storage: MEM_BYTES bytes. Effective index = address modulo MEM_BYTES (low log2(MEM_BYTES) bits); high address bits are ignored.
- Reset: already decided; one clock, reset synchronous and active-low.
  - When rst_n = 0 at a rising clk edge, every byte is cleared to 8'h00.
  - Reset has priority over a simultaneous write.
  - No write occurs in a cycle with rst_n = 0.
- Write (rising edge, rst_n = 1, wrEnable = 1):
  - numberOfByte = 1: mem[idx] <= in[7:0]; no other byte changes.
  - Otherwise: mem[idx] <= in[7:0] and mem[(idx+1) mod MEM_BYTES] <= in[15:8].
  - Little-endian; unaligned addresses are permitted.
  - The last location wraps to index 0.
- Read (combinational, zero latency):
  - rdEnable = 0: out = 16'h0000.
  - rdEnable = 1, numberOfByte = 1: out = {8'h00, mem[idx]} (zero-extended).
  - rdEnable = 1, other numberOfByte: out = {mem[(idx+1) mod MEM_BYTES], mem[idx]}.
  - `out` follows address, size and memory contents within the same cycle, with no clock dependency.
- Simultaneous rdEnable and wrEnable, same address:
  - During the cycle, `out` shows the pre-write contents.
  - After the edge, `out` reflects the new data (read-before-write per cycle).
- wrEnable = 0: memory contents hold indefinitely.
- Reset mid-operation: a pending write in the reset cycle is discarded. Reads during reset still show current (pre-clear) contents until the edge, then zeros.
- No X propagation: all bytes are defined after the first reset. Before the first reset the contents are undefined, and the bench must reset first.

Decomposition:
- Shared package (mem_pkg): constant SIZE_BYTE = 2'd1, constant SIZE_HALF = 2'd2, and a data-width constant of 16.
- No sub-module is required. The byte-lane write-enable/merge logic may optionally be factored into one helper, mem_byte_lanes, producing per-lane enables and next-index wrap.

Test Plan:
- Reset then read: rst_n = 0 for 1 edge; then rdEnable = 1, size = 2, address = 0x0010 -> out = 16'h0000; address 0x03FF -> 16'h0000.
- Halfword write/read: wrEnable = 1, size = 2, address = 0x0020, in = 16'hBEEF, one edge.
  - Then size = 1 reads: address 0x0020 -> 16'h00EF; address 0x0021 -> 16'h00BE.
  - size = 2 read at 0x0020 -> 16'hBEEF.
- Byte write isolation: after the above, wrEnable = 1, size = 1, address = 0x0021, in = 16'h1234 -> halfword read at 0x0020 = 16'h34EF; byte at 0x0022 unchanged (00).
- Wrap and aliasing:
  - size = 2 write at 0x03FF, in = 16'hA55A -> byte 0x03FF = 5A, byte 0x0000 = A5.
  - Read at address 0x07FF (alias, MEM_BYTES = 1024) -> 16'hA55A.
- Read-before-write / rdEnable gating:
  - Set 0x0040 = 16'h1111. Next cycle: rdEnable = 1, wrEnable = 1, in = 16'h2222 -> out = 16'h1111 before the edge, 16'h2222 after.
  - rdEnable = 0 -> out = 16'h0000.
- Reset priority: rst_n = 0 with wrEnable = 1, address 0x0050, in = 16'hFFFF at the same edge -> subsequent read of 0x0050 = 16'h0000; 0x0020 also reads 16'h0000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data memory: access-size codes and data width.
package mem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;
    localparam int         DATA_W    = 16;
endpackage

// File: rtl/mem_byte_lanes.sv
// Byte-lane decode: low/high byte indices (high wraps at the top of memory) and per-lane write enables.
module mem_byte_lanes
    import mem_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             wr_en,
    input  logic [1:0]       size,
    output logic [IDX_W-1:0] idx_lo,
    output logic [IDX_W-1:0] idx_hi,
    output logic             half,
    output logic [1:0]       lane_we
);
    // Only the byte code selects a single lane; every other size code is a halfword.
    assign half    = (size != SIZE_BYTE);
    assign idx_lo  = idx;
    assign idx_hi  = idx + IDX_W'(1);
    assign lane_we = {wr_en & half, wr_en};
endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory: synchronous write, combinational read,
// 1- or 2-byte accesses, synchronous active-low clear of every byte.
module data_memory
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrEnable,
    input  logic              rdEnable,
    input  logic [1:0]        numberOfByte,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out
);
    localparam int IDX_W = $clog2(MEM_BYTES);

    logic [7:0]       mem [MEM_BYTES];
    logic [IDX_W-1:0] idx_lo, idx_hi;
    logic             half;
    logic [1:0]       lane_we;

    // Upper address bits alias onto the same storage.
    generate
        if (ADDR_W > IDX_W) begin : g_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];
        end
    endgenerate

    mem_byte_lanes #(.IDX_W(IDX_W)) u_lanes (
        .idx     (address[IDX_W-1:0]),
        .wr_en   (wrEnable),
        .size    (numberOfByte),
        .idx_lo  (idx_lo),
        .idx_hi  (idx_hi),
        .half    (half),
        .lane_we (lane_we)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else begin
            if (lane_we[0]) mem[idx_lo] <= in[7:0];
            if (lane_we[1]) mem[idx_hi] <= in[15:8];
        end
    end

    // Read sees pre-edge contents, so a same-cycle write shows up only after the edge.
    always_comb begin
        out = '0;
        if (rdEnable) out = half ? {mem[idx_hi], mem[idx_lo]} : {8'h00, mem[idx_lo]};
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed plan plus randomized traffic vs a byte-array model.
module tb_data_memory;
    import mem_pkg::*;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wrEnable = 1'b0;
    logic        rdEnable = 1'b0;
    logic [1:0]  numberOfByte = 2'd0;
    logic [15:0] address = 16'h0;
    logic [15:0] in = 16'h0;
    logic [15:0] out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [MB];

    data_memory #(.MEM_BYTES(MB), .ADDR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrEnable     (wrEnable),
        .rdEnable     (rdEnable),
        .numberOfByte (numberOfByte),
        .address      (address),
        .in           (in),
        .out          (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic re, input logic [1:0] sz, input logic [15:0] a);
        int i;
        i = int'(a) % MB;
        if (!re) return 16'h0000;
        if (sz == SIZE_BYTE) return {8'h00, ref_mem[i]};
        return {ref_mem[(i + 1) % MB], ref_mem[i]};
    endfunction

    // One clock: drive at negedge, check the combinational read before the edge, update model at the edge.
    task automatic cyc(input logic r, input logic we, input logic re, input logic [1:0] sz,
                       input logic [15:0] a, input logic [15:0] d, input string tag, input bit do_chk);
        int i;
        @(negedge clk);
        rst_n = r; wrEnable = we; rdEnable = re; numberOfByte = sz; address = a; in = d;
        #1;
        if (do_chk) chk(tag, out, ref_rd(re, sz, a));
        @(posedge clk);
        i = int'(a) % MB;
        if (!r) begin
            for (int k = 0; k < MB; k++) ref_mem[k] = 8'h00;
        end else if (we) begin
            ref_mem[i] = d[7:0];
            if (sz != SIZE_BYTE) ref_mem[(i + 1) % MB] = d[15:8];
        end
    endtask

    // Read-only probe against a constant taken from the plan.
    task automatic rd(input logic re, input logic [1:0] sz, input logic [15:0] a,
                      input logic [15:0] exp, input string tag);
        @(negedge clk);
        rst_n = 1'b1; wrEnable = 1'b0; rdEnable = re; numberOfByte = sz; address = a;
        #1;
        chk(tag, out, exp);
    endtask

    initial begin
        logic [15:0] a, d;
        logic        r, we, re;
        logic [1:0]  sz;

        cyc(1'b0, 1'b0, 1'b0, SIZE_HALF, 16'h0, 16'h0, "reset", 1'b0);
        rd(1'b1, SIZE_HALF, 16'h0010, 16'h0000, "rst_0010");
        rd(1'b1, SIZE_HALF, 16'h03FF, 16'h0000, "rst_03ff");

        cyc(1'b1, 1'b1, 1'b0, SIZE_HALF, 16'h0020, 16'hBEEF, "hw_wr", 1'b1);
        rd(1'b1, SIZE_BYTE, 16'h0020, 16'h00EF, "b_0020");
        rd(1'b1, SIZE_BYTE, 16'h0021, 16'h00BE, "b_0021");
        rd(1'b1, SIZE_HALF, 16'h0020, 16'hBEEF, "h_0020");

        cyc(1'b1, 1'b1, 1'b0, SIZE_BYTE, 16'h0021, 16'h1234, "b_wr", 1'b1);
        rd(1'b1, SIZE_HALF, 16'h0020, 16'h34EF, "iso_h0020");
        rd(1'b1, SIZE_BYTE, 16'h0022, 16'h0000, "iso_b0022");

        cyc(1'b1, 1'b1, 1'b0, SIZE_HALF, 16'h03FF, 16'hA55A, "wrap_wr", 1'b1);
        rd(1'b1, SIZE_BYTE, 16'h03FF, 16'h005A, "wrap_b03ff");
        rd(1'b1, SIZE_BYTE, 16'h0000, 16'h00A5, "wrap_b0000");
        rd(1'b1, SIZE_HALF, 16'h07FF, 16'hA55A, "alias_07ff");
        rd(1'b1, 2'd3, 16'h03FF, 16'hA55A, "size3_03ff");

        cyc(1'b1, 1'b1, 1'b0, SIZE_HALF, 16'h0040, 16'h1111, "rbw_set", 1'b1);
        rd(1'b1, SIZE_HALF, 16'h0040, 16'h1111, "rbw_pre_chk");
        cyc(1'b1, 1'b1, 1'b1, SIZE_HALF, 16'h0040, 16'h2222, "rbw_pre", 1'b1);
        #1 chk("rbw_post", out, 16'h2222);
        rd(1'b0, SIZE_HALF, 16'h0040, 16'h0000, "rd_gate");

        cyc(1'b0, 1'b1, 1'b1, SIZE_HALF, 16'h0050, 16'hFFFF, "rst_prio", 1'b1);
        rd(1'b1, SIZE_HALF, 16'h0050, 16'h0000, "rst_prio_0050");
        rd(1'b1, SIZE_HALF, 16'h0020, 16'h0000, "rst_prio_0020");
        rd(1'b1, SIZE_HALF, 16'h0040, 16'h0000, "rst_prio_0040");

        // Random traffic clustered near the wrap point and low memory, with aliases and rare resets.
        for (int n = 0; n < 600; n++) begin
            a  = 16'($urandom_range(0, 15)) + ($urandom_range(0, 1) != 0 ? 16'h03F8 : 16'h0000)
                 + 16'($urandom_range(0, 63) << 10);
            d  = 16'($urandom);
            sz = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 2) != 0);
            re = ($urandom_range(0, 4) != 0);
            r  = ($urandom_range(0, 59) != 0);
            cyc(r, we, re, sz, a, d, "rand", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
